// File: rtl/aes256_block_loader.sv
// aes256_block_loader: assembles a 256-bit key and a 128-bit state block from
// a 32-bit word stream and presents them to the aes256 core in parallel.
// A block may reuse the previously loaded key, so it needs only four words.
//
// Optional feature macro: AES256_LOADER_PARITY_EN (even parity per word).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready word handshake; in_data payload, in_par parity bit
//   reuse_key         sampled with the first word of a block
//   blk_valid/blk_ready block handshake toward the core
//   key, state        assembled block (MSW first)
//   key_loaded        a full key has been loaded since reset
//   blk_err           parity error seen in the current block
module aes256_block_loader #(
  parameter int unsigned WORDS_KEY   = 8,
  parameter int unsigned WORDS_STATE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         reuse_key,
  input  logic         in_par,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [255:0] key,
  output logic [127:0] state,
  output logic         key_loaded,
  output logic         blk_err
);

  localparam int unsigned WCNT_W = 4;

  typedef enum logic [1:0] {LOAD_KEY, LOAD_STATE, PRESENT} fsm_t;

  fsm_t              fsm_q, fsm_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [255:0]      key_q;
  logic [127:0]      state_q;
  logic              key_loaded_q, key_loaded_d;
  logic              in_ready_q, blk_valid_q;
  logic              word_xfer_c, first_word_c, key_we_c, state_we_c;
  logic [2:0]        key_idx_c;
  logic [1:0]        state_idx_c;

  assign word_xfer_c = in_valid && in_ready_q;

  // Next-state, word counter and register write enables
  always_comb begin
    fsm_d        = fsm_q;
    wcnt_d       = wcnt_q;
    key_loaded_d = key_loaded_q;
    first_word_c = 1'b0;
    key_we_c     = 1'b0;
    state_we_c   = 1'b0;
    key_idx_c    = wcnt_q[2:0];
    state_idx_c  = wcnt_q[1:0];
    case (fsm_q)
      LOAD_KEY: begin
        if (word_xfer_c) begin
          first_word_c = (wcnt_q == '0);
          if (first_word_c && reuse_key && key_loaded_q) begin
            // Reused key: this word is already state word 0
            state_we_c  = 1'b1;
            state_idx_c = 2'd0;
            wcnt_d      = WCNT_W'(1);
            fsm_d       = LOAD_STATE;
          end else begin
            key_we_c = 1'b1;
            if (wcnt_q == WCNT_W'(WORDS_KEY - 1)) begin
              wcnt_d       = '0;
              key_loaded_d = 1'b1;
              fsm_d        = LOAD_STATE;
            end else begin
              wcnt_d = wcnt_q + WCNT_W'(1);
            end
          end
        end
      end
      LOAD_STATE: begin
        if (word_xfer_c) begin
          state_we_c = 1'b1;
          if (wcnt_q == WCNT_W'(WORDS_STATE - 1)) begin
            wcnt_d = '0;
            fsm_d  = PRESENT;
          end else begin
            wcnt_d = wcnt_q + WCNT_W'(1);
          end
        end
      end
      PRESENT: begin
        if (blk_valid_q && blk_ready) fsm_d = LOAD_KEY;
      end
      default: fsm_d = LOAD_KEY;
    endcase
  end

  // State register; handshake outputs registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= LOAD_KEY;
      wcnt_q       <= '0;
      key_loaded_q <= 1'b0;
      in_ready_q   <= 1'b1;
      blk_valid_q  <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      wcnt_q       <= wcnt_d;
      key_loaded_q <= key_loaded_d;
      in_ready_q   <= (fsm_d != PRESENT);
      blk_valid_q  <= (fsm_d == PRESENT);
    end
  end

  // Key/state assembly, word 0 lands in the most significant slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      state_q <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (key_we_c && key_idx_c == 3'(i)) key_q[255-32*i -: 32] <= in_data;
      end
      for (int j = 0; j < 4; j++) begin
        if (state_we_c && state_idx_c == 2'(j)) state_q[127-32*j -: 32] <= in_data;
      end
    end
  end

`ifdef AES256_LOADER_PARITY_EN
  logic blk_err_q;
  logic par_bad_c;

  assign par_bad_c = ^{in_data, in_par};

  // Sticky per-block parity flag, restarted by the first word of a block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_err_q <= 1'b0;
    end else if (word_xfer_c) begin
      blk_err_q <= first_word_c ? par_bad_c : (blk_err_q | par_bad_c);
    end
  end

  assign blk_err = blk_err_q;
`else
  logic unused_par;
  assign unused_par = in_par ^ first_word_c;
  assign blk_err    = 1'b0;
`endif

  assign in_ready   = in_ready_q;
  assign blk_valid  = blk_valid_q;
  assign key        = key_q;
  assign state      = state_q;
  assign key_loaded = key_loaded_q;

endmodule
